// File: rtl/dl_port_pkg.sv
// Shared types and defaults for the toggle-handshake port responder:
// address/queue sizing, FSM state encoding and the queued request layout.
package dl_port_pkg;

    localparam int DL_AW    = 23;
    localparam int DL_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        NOP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DL_AW-1:0] a;
        logic [1:0]       ds;
        logic             we;
        logic [15:0]      d;
    } req_t;

endpackage

// File: rtl/dl_req_fifo.sv
// Request queue between the toggle detector and the memory FSM.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dl_req_fifo
    import dl_port_pkg::*;
#(
    parameter int DEPTH = DL_DEPTH
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  req_t i_data,
    input  logic i_pop,
    output req_t o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] r_wr;
    logic [PW:0] r_rd;
    req_t        r_mem [DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[PW-1:0] == r_rd[PW-1:0]) && (r_wr[PW] != r_rd[PW]);

    // A pop in the same cycle frees the slot, so a push while full is still taken.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    assign o_head = r_mem[r_rd[PW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + (PW+1)'(1);
            if (w_do_pop)  r_rd <= r_rd + (PW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/dl_port_responder.sv
// Toggle-handshake port to level-handshake memory bridge. Port toggles are
// queued, then issued one at a time; each retirement flips port_ack.
module dl_port_responder
    import dl_port_pkg::*;
#(
    parameter int AW    = DL_AW,
    parameter int DEPTH = DL_DEPTH
) (
    input  logic          clk_mem,
    input  logic          reset_n,
    input  logic          port_req,
    input  logic [AW-1:0] port_a,
    input  logic [1:0]    port_ds,
    input  logic          port_we,
    input  logic [15:0]   port_d,
    output logic          port_ack,
    output logic [15:0]   port_q,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [1:0]    mem_be,
    output logic [15:0]   mem_d,
    input  logic          mem_ready,
    input  logic [15:0]   mem_q,
    output logic          busy,
    output logic          overflow
);

    state_t        r_state;
    state_t        w_next;
    logic          r_primed;
    logic          r_req_seen;
    logic          r_port_ack;
    logic [15:0]   r_port_q;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [1:0]    r_mem_be;
    logic [15:0]   r_mem_d;
    logic          r_overflow;

    logic          w_seen;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_ack_flip;
    logic          w_full;
    logic          w_empty;
    req_t          w_req;
    req_t          w_head;

    // r_primed stays low for the first cycle after reset so a stale high
    // port_req is absorbed into r_req_seen rather than seen as a toggle.
    assign w_seen = r_primed && (port_req != r_req_seen);
    assign w_req  = {port_a, port_ds, port_we, port_d};
    assign w_push = w_seen && (!w_full || w_pop);
    assign w_drop = w_seen && w_full && !w_pop;

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            r_primed   <= 1'b0;
            r_req_seen <= 1'b0;
        end else begin
            r_primed   <= 1'b1;
            r_req_seen <= port_req;
        end
    end

    dl_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk_mem),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_ack_flip = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = (w_head.ds == 2'b00) ? NOP : BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    w_ack_flip = 1'b1;
                    w_next     = IDLE;
                end
            end
            NOP: begin
                w_ack_flip = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            r_port_ack <= 1'b0;
            r_port_q   <= '0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_be   <= '0;
            r_mem_d    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_mem_addr <= w_head.a;
                r_mem_be   <= w_head.ds;
                r_mem_we   <= w_head.we;
                r_mem_d    <= w_head.we ? w_head.d : 16'h0000;
                r_mem_req  <= (w_head.ds != 2'b00);
            end
            if (r_state == BUSY && mem_ready) begin
                r_mem_req <= 1'b0;
                if (!r_mem_we) r_port_q <= mem_q;
            end
            if (w_ack_flip) r_port_ack <= ~r_port_ack;
            if (w_drop)     r_overflow <= 1'b1;
        end
    end

    assign port_ack = r_port_ack;
    assign port_q   = r_port_q;
    assign mem_req  = r_mem_req;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_be   = r_mem_be;
    assign mem_d    = r_mem_d;
    assign overflow = r_overflow;
    assign busy     = !w_empty || (r_state != IDLE);

endmodule

// File: doc/dl_port_responder.md
DL_PORT_RESPONDER -- requirements
Module: dl_port_responder

Interface
REQ-001 Parameter: AW, 23, word address width of port and memory side.
REQ-002 Parameter: DEPTH, 4, request FIFO entries, power of two, at least 2.
REQ-003 clk_mem  in  1  sole clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 port_req  in  1  toggle; each transition is one new request.
REQ-006 port_a  in  AW  request word address.
REQ-007 port_ds  in  2  byte enables {hi,lo}.
REQ-008 port_we  in  1  1=write, 0=read.
REQ-009 port_d  in  16  write data.
REQ-010 port_ack  out  1  toggle; flips once per retired request.
REQ-011 port_q  out  16  data of the last completed read.
REQ-012 mem_req  out  1  level; held high until mem_ready is sampled high.
REQ-013 mem_we, mem_addr, mem_be, mem_d  out  1/AW/2/16  memory command, stable while mem_req=1.
REQ-014 mem_ready  in  1  one-cycle completion; may be high in the first mem_req cycle.
REQ-015 mem_q  in  16  read data, valid with mem_ready.
REQ-016 busy  out  1  FIFO non-empty or state not IDLE.
REQ-017 overflow  out  1  sticky; a request was dropped.

Function
REQ-018 Toggle detect: a request is seen when port_req differs from internal req_seen; port_a/ds/we/d are sampled in that same cycle.
REQ-019 A seen request is pushed into the FIFO at that edge and req_seen takes port_req.
REQ-020 The initiator may toggle again before ack; each toggle is queued independently.
REQ-021 FIFO full on a seen request: the request is dropped, overflow is set, req_seen still updates, and port_ack does not flip.
REQ-022 Push and pop in the same cycle are permitted when full; the push is accepted.
REQ-023 FSM has three states: IDLE, BUSY and NOP.
REQ-024 IDLE with FIFO non-empty: pop the head into the command registers.
REQ-025 After the pop in IDLE, go to NOP if the head's ds=00, else go to BUSY.
REQ-026 BUSY drives mem_req=1 and stays until mem_ready=1.
REQ-027 At the BUSY edge where mem_ready=1: mem_req falls, port_ack flips, and the FSM goes to IDLE.
REQ-028 At that same edge, port_q takes mem_q if the request was a read; writes leave port_q unchanged.
REQ-029 NOP issues no memory access; at the next edge port_ack flips and the FSM goes to IDLE.
REQ-030 mem_be = popped ds; mem_we = popped we; mem_d = popped d, zero for reads.
REQ-031 Minimum latency is toggle sampled at edge 0, push at edge 0, BUSY at edge 1, with mem_ready in that cycle giving ack at edge 2.
REQ-032 Sustained throughput is one request per 2 cycles with zero-wait memory.
REQ-033 The FIFO pointers are log2(DEPTH) bits plus one wrap bit and wrap modulo 2*DEPTH.
REQ-034 FIFO full is defined as equal indices with differing wrap bits.
REQ-035 Requests retire strictly in arrival order.
REQ-036 port_ack equals port_req exactly when all non-dropped requests are retired and nothing has been dropped since reset.

Reset
REQ-037 reset_n low asynchronously clears: port_ack, port_q, mem_req, mem_we, mem_addr, mem_be, mem_d, overflow, busy, FIFO pointers, req_seen; state goes to IDLE.
REQ-038 Reset mid-BUSY abandons the access: mem_req drops immediately and no ack is given.
REQ-039 The first cycle after reset release is a prime cycle: req_seen takes port_req, no push occurs, and a stale port_req=1 is never treated as a request.

Structure
REQ-040 Shared package dl_port_pkg holds AW and DEPTH defaults, the state enum (IDLE, BUSY, NOP) and the packed request struct {a, ds, we, d}.
REQ-041 One sub-module, dl_req_fifo (synchronous, DEPTH x request struct, full/empty flags), holds the queue.
REQ-042 All other logic (toggle detect, FSM, command registers) is flat in dl_port_responder.

Verification
REQ-043 Single write: port_req 0->1, a=0x000100, ds=01, d=0xAB00, zero-wait memory -> one mem_req with be=01, addr=0x000100, and port_ack=1 at edge 2.
REQ-044 Burst: 4 toggles on consecutive cycles, mem_ready 3 cycles after each mem_req -> 4 accesses in order, overflow=0, final port_ack==port_req.
REQ-045 Overflow: 6 toggles on consecutive cycles with mem_ready held low, then released -> overflow=1, exactly DEPTH or DEPTH+1 accesses, port_ack!=port_req.
REQ-046 Read: we=0, a=0x7FFFFF, mem_q=0x1234 with ready -> port_q=0x1234 and port_ack flips; a following write leaves port_q=0x1234.
REQ-047 ds=00 request -> no mem_req, port_ack flips 2 cycles after the push.
REQ-048 Reset pulse during BUSY with port_req=1 held -> mem_req low immediately; after release no access occurs until port_req toggles again.
